// File: rtl/vec_load_pkg.sv
// Shared types and constants for the vector load sequencer: FSM states,
// command/bank byte values, error codes and timeout sizing.
package vec_load_pkg;

    localparam int unsigned WORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BANK,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_OP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;

    localparam logic [7:0] BANK_A = 8'h00;
    localparam logic [7:0] BANK_B = 8'h01;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_CMD    = 3'd1,
        ERR_BAD_BANK   = 3'd2,
        ERR_BAD_LEN    = 3'd3,
        ERR_TIMEOUT    = 3'd4,
        ERR_ACCEL_BUSY = 3'd5
    } err_code_t;

    // Idle byte-times converted to clock cycles (10 bit-times per UART byte).
    function automatic int unsigned calc_timeout_cycles(input int unsigned clk_hz,
                                                        input int unsigned baud,
                                                        input int unsigned n_bytes);
        return 32'(64'(n_bytes) * 64'd10 * 64'(clk_hz) / 64'(baud));
    endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte watchdog: counts cycles since the last received byte while a
// packet is in progress and flags expiry once CYCLES have elapsed.
module rx_timeout_timer #(
    parameter int unsigned CYCLES = 34722,
    localparam int unsigned CNT_W = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Saturating counter; idle (run low) keeps it parked at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CYCLES)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = run && (cnt == CNT_W'(CYCLES));

endmodule

// File: rtl/vector_load_sequencer.sv
// Packet parser between the UART byte stream and the A/B vector BRAM banks:
// sequences word writes, issues accelerator starts and reports errors.
module vector_load_sequencer
    import vec_load_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned MEMORY_DEPTH  = 1024,
    parameter int unsigned TIMEOUT_BYTES = 4,
    localparam int unsigned ADDR_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              accel_busy,
    output logic              wea_a,
    output logic              wea_b,
    output logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] d_in,
    output logic              start_op,
    output logic [7:0]        op_code,
    output logic              load_done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic              busy
);

    localparam int unsigned TIMEOUT_CYCLES =
        calc_timeout_cycles(CLK_FREQUENCY, BAUD_RATE, TIMEOUT_BYTES);

    state_t            state;
    logic              bank_b;
    logic [7:0]        len_hi;
    logic [7:0]        lo_byte;
    logic [ADDR_W-1:0] last_addr;
    logic [15:0]       len_c;
    logic              run_c;
    logic              timeout_c;

    assign len_c = {len_hi, rx_data};
    assign run_c = (state != ST_IDLE);

    rx_timeout_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (rx_ready),
        .run     (run_c),
        .expired (timeout_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bank_b    <= 1'b0;
            len_hi    <= '0;
            lo_byte   <= '0;
            last_addr <= '0;
            wea_a     <= 1'b0;
            wea_b     <= 1'b0;
            addr      <= '0;
            d_in      <= '0;
            start_op  <= 1'b0;
            op_code   <= '0;
            load_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
        end else begin
            wea_a     <= 1'b0;
            wea_b     <= 1'b0;
            start_op  <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;

            // Advance the address the cycle after a non-final write.
            if ((wea_a || wea_b) && !load_done) begin
                addr <= addr + ADDR_W'(1);
            end

            if (rx_ready) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == CMD_WRITE) begin
                            state <= ST_BANK;
                            busy  <= 1'b1;
                        end else if (rx_data == CMD_START) begin
                            state <= ST_OP;
                            busy  <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_CMD;
                        end
                    end
                    ST_BANK: begin
                        if (rx_data == BANK_A || rx_data == BANK_B) begin
                            bank_b <= (rx_data == BANK_B);
                            state  <= ST_LEN_HI;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_BANK;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end
                    end
                    ST_LEN_HI: begin
                        len_hi <= rx_data;
                        state  <= ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        if (len_c == 16'd0 || 32'(len_c) > MEMORY_DEPTH) begin
                            err      <= 1'b1;
                            err_code <= ERR_BAD_LEN;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            last_addr <= ADDR_W'(len_c - 16'd1);
                            addr      <= '0;
                            state     <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        lo_byte <= rx_data;
                        state   <= ST_DATA_HI;
                    end
                    ST_DATA_HI: begin
                        d_in  <= {rx_data[1:0], lo_byte};
                        wea_a <= !bank_b;
                        wea_b <= bank_b;
                        if (addr == last_addr) begin
                            load_done <= 1'b1;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state <= ST_DATA_LO;
                        end
                    end
                    ST_OP: begin
                        if (!accel_busy) begin
                            op_code  <= rx_data;
                            start_op <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_ACCEL_BUSY;
                        end
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (timeout_c) begin
                // A byte arriving on the expiry cycle takes the branch above instead.
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= ST_IDLE;
                busy     <= 1'b0;
            end
        end
    end

endmodule
